// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helper for the ALU round-robin scheduler.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_LAST = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr (modulo NUM_REQ).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // NOTE: every output and temporary gets a default first so no path leaves a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // One extra bit keeps ptr+off from overflowing before the wrap.
      sum = {1'b0, ptr} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!grant_any && req[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters.
// Optional build macro ALU_OP_CHECK_EN: flags opcodes above OP_LAST via rsp_err and bypasses the ALU for them.
module alu_rr_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_sel,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_carry
`ifdef ALU_OP_CHECK_EN
  ,output logic                 rsp_err
`endif
);

  logic [1:0]         state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [2:0]         sel_op;
`ifdef ALU_OP_CHECK_EN
  logic               illegal_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Payload of the winning requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE) ? grant : '0;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;

  // NOTE: sequential state uses non-blocking assignments only; every register, op latches included, is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= OP_AND;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
`ifdef ALU_OP_CHECK_EN
      illegal_q <= 1'b0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_any) begin
            // The ALU drive registers double as the op latches, so they hold between ops.
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            id_q    <= grant_idx;
            state_q <= S_EXEC;
`ifdef ALU_OP_CHECK_EN
            illegal_q <= !op_is_legal(sel_op);
            alu_sel   <= op_is_legal(sel_op) ? sel_op : OP_AND;
`else
            alu_sel   <= sel_op;
`endif
          end
        end
        S_EXEC: begin
`ifdef ALU_OP_CHECK_EN
          rsp_data  <= illegal_q ? '0 : alu_out;
          rsp_carry <= illegal_q ? 1'b0 : alu_carry;
          rsp_err   <= illegal_q;
`else
          rsp_data  <= alu_out;
          rsp_carry <= alu_carry;
`endif
          ptr_q   <= (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: vector table, directed multi-cycle sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_rr_scheduler;
  import alu_ctrl_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 4;
`ifdef ALU_OP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [11:0] req_op;
  logic [3:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        rsp_carry;
`ifdef ALU_OP_CHECK_EN
  logic        rsp_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
`ifdef ALU_OP_CHECK_EN
    , .rsp_err(rsp_err)
`endif
  );

  // Stand-in for the shared ALU: {carry, result}; unknown selects give 0.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    int s;
    case (sel)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~a};
      3'd3: begin s = int'(a) + int'(b); return 5'(s); end
      3'd4: begin s = int'(a) - int'(b); return {a < b, 4'(s)}; end
      default: return 5'd0;
    endcase
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  // Expected response {err, carry, data} for one op.
  function automatic logic [5:0] exp_rsp(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    if (op > 3'd4) return {CHECK_EN, 5'd0};
    return {1'b0, alu_fn(a, b, op)};
  endfunction

  function automatic logic [2:0] exp_sel(input logic [2:0] op);
    return (CHECK_EN && op > 3'd4) ? 3'd0 : op;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_valid[i[1:0]] = 1'b1;
    req_a[i*4 +: 4]   = a;
    req_b[i*4 +: 4]   = b;
    req_op[i*3 +: 3]  = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  // Requesters must not drop valid before their ready; enabled while the random stimulus runs.
  logic       chk_hold = 1'b0;
  logic [3:0] prev_pend = '0;
  always @(posedge clk) begin
    if (chk_hold && rst_n)
      for (int i = 0; i < NUM_REQ; i++)
        assert (!(prev_pend[i] && !req_valid[i])) else $error("requester %0d retracted valid", i);
    prev_pend <= req_valid & ~req_ready;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] data;
    logic       carry;
    logic       illegal;
  } vec_t;

  vec_t vecs [10];

  // One isolated op: ready in the offer cycle, ALU driven in EXEC, response two cycles after accept.
  task automatic run_one(input int id, input vec_t v);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(id, v.a, v.b, v.op);
    #1 check("tbl_ready", req_ready, 32'(1 << id));
    @(negedge clk);
    req_valid = '0;
    #1;
    check("tbl_exec_no_rsp", rsp_valid, 0);
    check("tbl_alu_a", alu_a, v.a);
    check("tbl_alu_b", alu_b, v.b);
    check("tbl_alu_sel", alu_sel, exp_sel(v.op));
    @(negedge clk);
    #1;
    check("tbl_rsp_valid", rsp_valid, 1);
    check("tbl_rsp_id", rsp_id, id);
    check("tbl_rsp_data", rsp_data, v.data);
    check("tbl_rsp_carry", rsp_carry, v.carry);
`ifdef ALU_OP_CHECK_EN
    check("tbl_rsp_err", rsp_err, v.illegal);
`endif
  endtask

  task automatic run_random(input int cycles);
    logic [3:0] acc, exp_rdy;
    logic [5:0] e;
    logic [3:0] e_a, e_b;
    logic [2:0] e_op;
    int ptr_m, g, g_cyc, j;
    bit busy;
    acc = '0; ptr_m = 0; g = 0; g_cyc = 0; busy = 1'b0;
    e_a = '0; e_b = '0; e_op = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~acc;
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = '0;
      if (!busy)
        for (int off = 0; off < NUM_REQ; off++) begin
          j = (ptr_m + off) % NUM_REQ;
          if (exp_rdy == '0 && req_valid[j]) begin
            exp_rdy = 4'(1 << j);
            g = j;
          end
        end
      check("rnd_ready", req_ready, exp_rdy);
      if (busy && c == g_cyc + 1) begin
        check("rnd_alu_a", alu_a, e_a);
        check("rnd_alu_b", alu_b, e_b);
        check("rnd_alu_sel", alu_sel, exp_sel(e_op));
      end
      check("rnd_rsp_valid", rsp_valid, busy && c >= g_cyc + 2);
      if (busy && rsp_valid && rsp_ready) begin
        e = exp_rsp(e_a, e_b, e_op);
        check("rnd_rsp_id", rsp_id, 32'(ptr_m == 0 ? NUM_REQ - 1 : ptr_m - 1));
        check("rnd_rsp_data", rsp_data, e[3:0]);
        check("rnd_rsp_carry", rsp_carry, e[4]);
`ifdef ALU_OP_CHECK_EN
        check("rnd_rsp_err", rsp_err, e[5]);
`endif
        busy = 1'b0;
      end
      if (exp_rdy != '0) begin
        busy  = 1'b1;
        g_cyc = c;
        e_a   = req_a[g*4 +: 4];
        e_b   = req_b[g*4 +: 4];
        e_op  = req_op[g*3 +: 3];
        ptr_m = (g + 1) % NUM_REQ;
      end
      acc = req_ready & req_valid;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    vecs[0] = '{a:4'h9, b:4'h8, op:OP_ADD, data:4'h1, carry:1'b1, illegal:1'b0};
    vecs[1] = '{a:4'h3, b:4'h5, op:OP_SUB, data:4'hE, carry:1'b1, illegal:1'b0};
    vecs[2] = '{a:4'hC, b:4'hA, op:OP_AND, data:4'h8, carry:1'b0, illegal:1'b0};
    vecs[3] = '{a:4'hC, b:4'hA, op:OP_OR,  data:4'hE, carry:1'b0, illegal:1'b0};
    vecs[4] = '{a:4'h5, b:4'h3, op:OP_NOT, data:4'hA, carry:1'b0, illegal:1'b0};
    vecs[5] = '{a:4'h7, b:4'h2, op:OP_SUB, data:4'h5, carry:1'b0, illegal:1'b0};
    vecs[6] = '{a:4'hF, b:4'hF, op:OP_ADD, data:4'hE, carry:1'b1, illegal:1'b0};
    vecs[7] = '{a:4'h6, b:4'h3, op:3'b110, data:4'h0, carry:1'b0, illegal:1'b1};
    vecs[8] = '{a:4'hF, b:4'h1, op:3'b111, data:4'h0, carry:1'b0, illegal:1'b1};
    vecs[9] = '{a:4'h4, b:4'h4, op:3'b101, data:4'h0, carry:1'b0, illegal:1'b1};

    // Reset state
    @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_carry", rsp_carry, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) run_one(k % NUM_REQ, vecs[k]);

    // Round-robin: all four continuously valid from a fresh pointer.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i + 1), 4'h1, OP_ADD);
    for (int k = 0; k < 5; k++) begin
      #1 check("rr_grant", req_ready, 32'(1 << (k % NUM_REQ)));
      @(negedge clk);
      #1 check("rr_exec_ready", req_ready, 0);
      @(negedge clk);
      #1;
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id", rsp_id, k % NUM_REQ);
      check("rr_rsp_data", rsp_data, (k % NUM_REQ) + 2);
      @(negedge clk);
    end

    // Backpressure: pointer now 1, all still valid, response held for five cycles.
    rsp_ready = 1'b0;
    #1 check("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 1);
      check("bp_rsp_data", rsp_data, 4'h3);
      check("bp_rsp_carry", rsp_carry, 0);
      check("bp_req_ready", req_ready, 0);
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 check("bp_release_valid", rsp_valid, 1);
    @(negedge clk);
    #1;
    check("bp_idle_rsp_valid", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b0100);

    // Reset while req2's op is in EXEC.
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_sel", alu_sel, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_rsp_id", rsp_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    #1;
    check("post_rst_no_rsp", rsp_valid, 0);
    check("post_rst_ptr_zero", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 check("post_rst_rsp_id1", rsp_id, 1);
    @(negedge clk);
    req_valid = 4'b0100;
    #1 check("post_rst_req2_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check("post_rst_rsp_valid", rsp_valid, 1);
    check("post_rst_rsp_id2", rsp_id, 2);
    check("post_rst_rsp_data", rsp_data, 4'h4);

    // Randomized traffic against the transaction-level model.
    do_reset();
    chk_hold = 1'b1;
    run_random(900);
    chk_hold = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
